// File: rtl/lift_car_controller.sv
// lift_car_controller
// Per-car responder of the lift dispatch interface. Latches calls addressed
// to this car as pending stops and serves them floor by floor under a SCAN
// policy: keep going the current way while calls remain ahead, then reverse.
module lift_car_controller #(
  parameter int LIFT_ID     = 1,
  parameter int NUM_FLOORS  = 10,
  parameter int HOME_FLOOR  = 1,
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [3:0]            req_floor,
  input  logic [2:0]            req_lift,
  output logic                  req_ready,
  output logic [3:0]            cur_floor,
  output logic [1:0]            dir,
  output logic                  door_open,
  output logic                  arrived,
  output logic [3:0]            arrived_floor,
  output logic                  bad_req,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam int TICK_MAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);
  localparam logic [3:0]    HOME       = 4'(HOME_FLOOR);
  localparam logic [3:0]    TOP        = 4'(NUM_FLOORS);
  localparam logic [2:0]    MY_ID      = 3'(LIFT_ID);

  // One-hot stop vector for floor f (bit f-1).
  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [3:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (f == 4'(i + 1));
    return m;
  endfunction

  // Stops strictly above floor f.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [3:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (4'(i + 1) > f);
    return m;
  endfunction

  // Stops strictly below floor f.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [3:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (4'(i + 1) < f);
    return m;
  endfunction

  state_t                r_state;
  logic [TW-1:0]         r_tick;
  logic [3:0]            r_cur_floor;
  logic [1:0]            r_dir;
  logic                  r_door;
  logic                  r_arrived;
  logic [3:0]            r_arrived_floor;
  logic                  r_bad_req;
  logic [NUM_FLOORS-1:0] r_pending;
  logic                  r_last_up;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_dwell_hit;
  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_pend_set;
  logic                  w_here;
  logic                  w_any_above;
  logic                  w_any_below;
  logic [3:0]            w_step_floor;
  logic                  w_step_hit;
  logic                  w_step_more;
  logic                  w_at_limit;

  assign req_ready = ~reset;

  // Call decode and the look-ahead used by the SCAN decisions.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_accept     = req_valid && req_ready && (req_lift == MY_ID);
    w_in_range   = (req_floor != 4'd0) && (req_floor <= TOP);
    // A repeat call for the floor being served only extends the dwell.
    w_dwell_hit  = w_accept && w_in_range && (r_state == DOOR_OPEN) &&
                   (req_floor == r_cur_floor);
    w_set        = (w_accept && w_in_range && !w_dwell_hit) ? floor_mask(req_floor) : '0;
    w_pend_set   = r_pending | w_set;
    w_here       = |(r_pending & floor_mask(r_cur_floor));
    w_any_above  = |(r_pending & above_mask(r_cur_floor));
    w_any_below  = |(r_pending & below_mask(r_cur_floor));
    w_step_floor = (r_state == MOVE_UP) ? r_cur_floor + 4'd1 : r_cur_floor - 4'd1;
    // Stop decisions use the registered stops: a call landing on the very
    // edge the car reaches that floor is not served by this pass.
    w_step_hit   = |(r_pending & floor_mask(w_step_floor));
    w_step_more  = (r_state == MOVE_UP) ? |(w_pend_set & above_mask(w_step_floor))
                                        : |(w_pend_set & below_mask(w_step_floor));
    w_at_limit   = ((r_state == MOVE_UP)   && (r_cur_floor >= TOP)) ||
                   ((r_state == MOVE_DOWN) && (r_cur_floor <= 4'd1));
  end

  // Car FSM: state, position, stop bookkeeping and all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state         <= IDLE;
      r_tick          <= '0;
      r_cur_floor     <= HOME;
      r_dir           <= DIR_IDLE;
      r_door          <= 1'b0;
      r_arrived       <= 1'b0;
      r_arrived_floor <= HOME;
      r_bad_req       <= 1'b0;
      r_pending       <= '0;
      r_last_up       <= 1'b1;
    end else begin
      r_arrived <= 1'b0;
      r_bad_req <= w_accept && !w_in_range;
      r_pending <= w_pend_set;
      case (r_state)
        IDLE: begin
          r_tick <= '0;
          if (w_here) begin
            r_state         <= DOOR_OPEN;
            r_door          <= 1'b1;
            r_dir           <= DIR_IDLE;
            r_pending       <= w_pend_set & ~floor_mask(r_cur_floor);
            r_arrived       <= 1'b1;
            r_arrived_floor <= r_cur_floor;
          end else if (w_any_above && (!w_any_below || r_last_up)) begin
            r_state   <= MOVE_UP;
            r_dir     <= DIR_UP;
            r_last_up <= 1'b1;
          end else if (w_any_below) begin
            r_state   <= MOVE_DOWN;
            r_dir     <= DIR_DOWN;
            r_last_up <= 1'b0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (w_at_limit) begin
            r_state <= IDLE;
            r_dir   <= DIR_IDLE;
            r_tick  <= '0;
          end else if (r_tick == FLOOR_LAST) begin
            r_tick      <= '0;
            r_cur_floor <= w_step_floor;
            if (w_step_hit) begin
              r_state         <= DOOR_OPEN;
              r_door          <= 1'b1;
              r_dir           <= DIR_IDLE;
              r_pending       <= w_pend_set & ~floor_mask(w_step_floor);
              r_arrived       <= 1'b1;
              r_arrived_floor <= w_step_floor;
            end else if (!w_step_more) begin
              r_state <= IDLE;
              r_dir   <= DIR_IDLE;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        DOOR_OPEN: begin
          if (w_dwell_hit) begin
            r_tick <= '0;
          end else if (r_tick == DOOR_LAST) begin
            r_state <= IDLE;
            r_door  <= 1'b0;
            r_tick  <= '0;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dir   <= DIR_IDLE;
          r_door  <= 1'b0;
          r_tick  <= '0;
        end
      endcase
    end
  end

  assign cur_floor     = r_cur_floor;
  assign dir           = r_dir;
  assign door_open     = r_door;
  assign arrived       = r_arrived;
  assign arrived_floor = r_arrived_floor;
  assign bad_req       = r_bad_req;
  assign pending       = r_pending;

endmodule
